dds_freq_meter: RTL and testbench

Gate-time frequency meter on the receive side of the DDS sample stream: takes the 10-bit unsigned waveform samples the DDS wave generator produces, detects rising mid-scale crossings with hysteresis, counts them over a fixed gate of 2^GATE_LOG2 clocks, and reports the equivalent 32-bit tuning word K together with the last measured period. It sits beside the DDS generator in loopback and self-test paths, closing the loop from K to waveform back to K.

---
 rtl/dds_pkg.sv | 20 ++
 rtl/dds_cross_det.sv | 53 +++++
 rtl/dds_freq_meter.sv | 152 +++++++++++++++
 tb/tb_dds_freq_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared constants and types for the DDS receive-side monitors.
//   SAMPLE_W : width of the offset-binary waveform sample
//   MID      : mid-scale code of the sample
//   K_W      : width of the DDS tuning word
//   state_e  : measurement FSM states of the frequency meter
// -----------------------------------------------------------------------------
package dds_pkg;
    localparam int SAMPLE_W = 10;
    localparam int MID      = 512;
    localparam int K_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/dds_cross_det.sv
// -----------------------------------------------------------------------------
// dds_cross_det
// Registers the incoming sample once, then runs a two-state Schmitt detector
// around mid-scale. A one-cycle xing pulse marks each rising crossing of the
// upper threshold; falling through the lower threshold re-arms silently.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset (detector returns to HIGH)
//   sample_in in  SAMPLE_W-bit unsigned offset-binary sample
//   xing      out one-cycle rising-crossing pulse, two cycles after the sample
// -----------------------------------------------------------------------------
module dds_cross_det
    import dds_pkg::*;
#(
    parameter int HYST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                xing
);
    localparam logic [31:0] HI_TH = 32'(MID + HYST);
    localparam logic [31:0] LO_TH = 32'(MID - HYST);

    logic [SAMPLE_W-1:0] sample_q;
    logic                high_q;
    logic                xing_q;
    logic [31:0]         sample_ext;

    assign sample_ext = 32'(sample_q);

    // Starting in HIGH means a waveform has to visit the low band before its
    // first crossing can be reported, so a reset during a high plateau does
    // not produce a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            high_q   <= 1'b1;
            xing_q   <= 1'b0;
        end else begin
            sample_q <= sample_in;
            xing_q   <= 1'b0;
            if (!high_q && (sample_ext >= HI_TH)) begin
                high_q <= 1'b1;
                xing_q <= 1'b1;
            end else if (high_q && (sample_ext < LO_TH)) begin
                high_q <= 1'b0;
            end
        end
    end

    assign xing = xing_q;
endmodule

// File: rtl/dds_freq_meter.sv
// -----------------------------------------------------------------------------
// dds_freq_meter
// Gate-time frequency meter: aligns a 2^GATE_LOG2-clock gate to a rising
// mid-scale crossing, counts crossings inside the gate and reports the
// equivalent DDS tuning word plus the last crossing-to-crossing period.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       begin a measurement (honoured only while idle)
//   sample_in   SAMPLE_W-bit offset-binary waveform sample, one per clock
//   busy        high while arming, gating or holding a result
//   res_valid   result available; held until res_ready
//   res_ready   result accepted on res_valid && res_ready
//   k_est       estimated tuning word
//   cross_cnt   rising crossings counted in the gate (saturating)
//   period_cyc  clocks between the last two counted crossings
//   timeout     no crossing seen while arming
// -----------------------------------------------------------------------------
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int GATE_LOG2 = 16,
    parameter int HYST      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SAMPLE_W-1:0]  sample_in,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [K_W-1:0]       k_est,
    output logic [GATE_LOG2-1:0] cross_cnt,
    output logic [31:0]          period_cyc,
    output logic                 timeout
);
    state_e               state_q, state_d;
    logic                 xing;
    logic [GATE_LOG2-1:0] cnt_q;
    logic [GATE_LOG2-1:0] cross_q, cross_d;
    logic [31:0]          per_q;
    logic [31:0]          period_q;
    logic [K_W-1:0]       k_q;
    logic                 timeout_q;
    logic                 cnt_last;

    dds_cross_det #(
        .HYST      (HYST)
    ) u_cross_det (
        .clk       (clk),
        .rst       (rst),
        .sample_in (sample_in),
        .xing      (xing)
    );

    // cnt_q runs 0..2^GATE_LOG2-1 across both ARM and GATE, so all-ones marks
    // the 2^GATE_LOG2-th cycle of either phase.
    assign cnt_last = (cnt_q == '1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = ARM;
            ARM: begin
                if (xing) begin
                    state_d = GATE;
                end else if (cnt_last) begin
                    state_d = DONE;
                end
            end
            GATE: if (cnt_last) state_d = DONE;
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q != IDLE);
        res_valid = (state_q == DONE);
    end

    // Saturating crossing count; includes a crossing on the final gate cycle.
    always_comb begin
        cross_d = cross_q;
        if ((state_q == GATE) && xing && (cross_q != '1)) begin
            cross_d = cross_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            cross_q   <= '0;
            per_q     <= '0;
            period_q  <= '0;
            k_q       <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q     <= '0;
                        cross_q   <= '0;
                        per_q     <= '0;
                        period_q  <= '0;
                        k_q       <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ARM: begin
                    if (xing) begin
                        cnt_q <= '0;
                    end else if (cnt_last) begin
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GATE: begin
                    cnt_q   <= cnt_q + 1'b1;
                    cross_q <= cross_d;
                    // Reload with 1 so the value seen at the next crossing
                    // equals the clocks elapsed since this one.
                    per_q   <= xing ? 32'd1 : per_q + 32'd1;
                    if (xing && (cross_q != '0)) begin
                        period_q <= per_q;
                    end
                    // k = count * 2^32 / 2^GATE_LOG2, i.e. a plain left shift.
                    if (cnt_last) begin
                        k_q <= {cross_d, {(K_W-GATE_LOG2){1'b0}}};
                    end
                end
                default: ;
            endcase
        end
    end

    assign k_est      = k_q;
    assign cross_cnt  = cross_q;
    assign period_cyc = period_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_dds_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_dds_freq_meter
// Scoreboard bench: each measurement pushes its hand-computed result into a
// queue; a monitor pops and compares on every accepted result. The gate is
// shortened to 2^12 clocks; the tuning word is independent of gate length.
// -----------------------------------------------------------------------------
module tb_dds_freq_meter;
    localparam int G = 12;

    typedef struct {
        logic [31:0] k;
        logic [31:0] cnt;
        logic [31:0] per;
        logic        to;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [9:0]   sample_in;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  k_est;
    logic [G-1:0] cross_cnt;
    logic [31:0]  period_cyc;
    logic         timeout;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mode     = 0;
    exp_t exp_q[$];

    // Hand-computed expectations for a 4096-clock gate
    localparam exp_t EXP_SQ = '{k: 32'h0400_0000, cnt: 32'd64,   per: 32'd64, to: 1'b0};
    localparam exp_t EXP_TO = '{k: 32'h0000_0000, cnt: 32'd0,    per: 32'd0,  to: 1'b1};
    localparam exp_t EXP_P2 = '{k: 32'h8000_0000, cnt: 32'd2048, per: 32'd2,  to: 1'b0};

    dds_freq_meter #(
        .GATE_LOG2  (G),
        .HYST       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sample_in  (sample_in),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .k_est      (k_est),
        .cross_cnt  (cross_cnt),
        .period_cyc (period_cyc),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waveform source: 0 square period 64, 1 constant mid-scale,
    // 2 square period 64 with noisy mid-scale dwell, 3 period-2 alternation
    initial begin
        int cyc;
        int p;
        int v;
        cyc = 0;
        sample_in = 10'd0;
        forever begin
            @(posedge clk);
            #1;
            p = cyc % 64;
            case (mode)
                1: v = 512;
                2: begin
                    if ((p < 4) || ((p >= 32) && (p < 36))) begin
                        v = 512 + int'($urandom_range(20)) - 10;
                    end else begin
                        v = (p < 32) ? 1023 : 0;
                    end
                end
                3: v = (cyc % 2 == 0) ? 0 : 1023;
                default: v = (p < 32) ? 1023 : 0;
            endcase
            sample_in = 10'(v);
            cyc++;
        end
    end

    // Monitor: compare every accepted result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got 1 result expected 0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result k_est=0x%08h cross_cnt=%0d period_cyc=%0d timeout=%0b",
                         k_est, cross_cnt, period_cyc, timeout);
                chk("k_est", k_est, e.k);
                chk("cross_cnt", 32'(cross_cnt), e.cnt);
                chk("period_cyc", period_cyc, e.per);
                chk("timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!res_valid && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_reached", 32'(res_valid), 32'd1);
    endtask

    task automatic run_meas(input exp_t e);
        exp_q.push_back(e);
        pulse_start();
        wait_valid(3 * (1 << G) + 200);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_k_est", k_est, 32'd0);
        chk("rst_cross_cnt", 32'(cross_cnt), 32'd0);
        chk("rst_period_cyc", period_cyc, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        repeat (100) @(posedge clk);

        // Clean square wave, K = 2^26
        run_meas(EXP_SQ);

        // Constant mid-scale: arming times out
        mode = 1;
        repeat (10) @(posedge clk);
        run_meas(EXP_TO);

        // Noise inside the hysteresis band adds no crossings
        mode = 2;
        repeat (100) @(posedge clk);
        run_meas(EXP_SQ);

        // Back-pressure: result held, start ignored while DONE
        mode = 0;
        res_ready = 1'b0;
        repeat (100) @(posedge clk);
        exp_q.push_back(EXP_SQ);
        pulse_start();
        wait_valid(3 * (1 << G) + 200);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 start = (i == 50);
            @(negedge clk);
            if ((i % 25) == 0 || i == 51) begin
                chk("hold_res_valid", 32'(res_valid), 32'd1);
                chk("hold_k_est", k_est, EXP_SQ.k);
                chk("hold_cross_cnt", 32'(cross_cnt), EXP_SQ.cnt);
                chk("hold_period_cyc", period_cyc, EXP_SQ.per);
            end
        end
        @(posedge clk);
        #1 begin
            start = 1'b0;
            res_ready = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        chk("accept_busy", 32'(busy), 32'd0);
        chk("accept_res_valid", 32'(res_valid), 32'd0);
        chk("accept_k_kept", k_est, EXP_SQ.k);

        // Reset in the middle of the gate
        repeat (10) @(posedge clk);
        pulse_start();
        repeat (1000) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_k_est", k_est, 32'd0);
        chk("midrst_cross_cnt", 32'(cross_cnt), 32'd0);
        chk("midrst_period_cyc", period_cyc, 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        repeat (100) @(posedge clk);
        run_meas(EXP_SQ);

        // Fastest waveform: period 2, K = 2^31
        mode = 3;
        repeat (10) @(posedge clk);
        run_meas(EXP_P2);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
